// File: rtl/hazard_sb.sv
// Decode-stage hazard scoreboard: per-port forwarding selects, load-use and mult/div stalls.
// Forwarding and stall are combinational; the mult/div busy counter and stall statistic are registered.
module hazard_sb #(
    parameter int AW      = 5,
    parameter int NRP     = 2,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRP*AW-1:0]   D_RsAddrs,
    input  logic [NRP-1:0]      D_RdUse,
    input  logic                E_WriteReg,
    input  logic                E_MemRead,
    input  logic [AW-1:0]       E_RD,
    input  logic                M_WriteReg,
    input  logic                M_MemRead,
    input  logic [AW-1:0]       M_RD,
    input  logic                W_WriteReg,
    input  logic [AW-1:0]       W_RegWriteAddr,
    input  logic                D_MDStart,
    input  logic                D_MDIsDiv,
    input  logic                D_ReadHiLo,
    input  logic                StatClr,
    output logic [2*NRP-1:0]    FWD,
    output logic                Stall,
    output logic                FlushE,
    output logic                MD_Busy,
    output logic [15:0]         StallCnt
);

    localparam logic [7:0] MUL_LOAD = 8'(MUL_LAT);
    localparam logic [7:0] DIV_LOAD = 8'(DIV_LAT);

    logic [2*NRP-1:0] fwd_sel;
    logic [NRP-1:0]   port_lu;
    logic             md_stall;
    logic             stall_raw;
    logic             md_accept;

    logic [7:0]       busy_q, busy_d;
    logic [15:0]      cnt_q, cnt_d;

    for (genvar gi = 0; gi < NRP; gi++) begin : g_port
        logic [AW-1:0] addr;
        logic          used;
        logic          e_hit;
        logic          m_hit;
        logic          w_hit;

        assign addr  = D_RsAddrs[gi*AW +: AW];
        // Reads of r0 never hazard, so a zero address is treated as unused.
        assign used  = D_RdUse[gi] && (addr != '0);
        assign e_hit = used && E_WriteReg && (E_RD == addr);
        assign m_hit = used && M_WriteReg && (M_RD == addr);
        assign w_hit = used && W_WriteReg && (W_RegWriteAddr == addr);

        assign fwd_sel[2*gi +: 2] = e_hit ? 2'b01 :
                                    m_hit ? 2'b10 :
                                    w_hit ? 2'b11 : 2'b00;

        // A load in M only matters when E does not shadow it with a younger write.
        assign port_lu[gi] = (e_hit && E_MemRead) || (m_hit && !e_hit && M_MemRead);
    end

    assign MD_Busy   = (busy_q != 8'd0);
    assign md_stall  = MD_Busy && (D_ReadHiLo || D_MDStart);
    assign stall_raw = (|port_lu) || md_stall;

    assign Stall     = stall_raw && !rst;
    assign FlushE    = Stall;
    assign FWD       = rst ? '0 : fwd_sel;
    assign StallCnt  = cnt_q;

    assign md_accept = D_MDStart && !Stall;

    always_comb begin
        busy_d = busy_q;
        if (md_accept) begin
            busy_d = D_MDIsDiv ? DIV_LOAD : MUL_LOAD;
        end else if (busy_q != 8'd0) begin
            busy_d = busy_q - 8'd1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (StatClr) begin
            cnt_d = 16'd0;
        end else if (Stall && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 8'd0;
            cnt_q  <= 16'd0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_sb.sv
// Bench for hazard_sb: directed scenarios plus randomized cycles against a behavioural reference.
module tb_hazard_sb;

    localparam int AW      = 5;
    localparam int NRP     = 2;
    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NRP*AW-1:0] D_RsAddrs;
    logic [NRP-1:0]    D_RdUse;
    logic              E_WriteReg, E_MemRead;
    logic [AW-1:0]     E_RD;
    logic              M_WriteReg, M_MemRead;
    logic [AW-1:0]     M_RD;
    logic              W_WriteReg;
    logic [AW-1:0]     W_RegWriteAddr;
    logic              D_MDStart, D_MDIsDiv, D_ReadHiLo, StatClr;
    logic [2*NRP-1:0]  FWD;
    logic              Stall, FlushE, MD_Busy;
    logic [15:0]       StallCnt;

    int checks = 0;
    int errors = 0;

    // Reference state: cycles of mult/div work remaining and stall cycles seen.
    int m_busy = 0;
    int m_cnt  = 0;

    always #5 clk = ~clk;

    hazard_sb #(.AW(AW), .NRP(NRP), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst(rst),
        .D_RsAddrs(D_RsAddrs), .D_RdUse(D_RdUse),
        .E_WriteReg(E_WriteReg), .E_MemRead(E_MemRead), .E_RD(E_RD),
        .M_WriteReg(M_WriteReg), .M_MemRead(M_MemRead), .M_RD(M_RD),
        .W_WriteReg(W_WriteReg), .W_RegWriteAddr(W_RegWriteAddr),
        .D_MDStart(D_MDStart), .D_MDIsDiv(D_MDIsDiv), .D_ReadHiLo(D_ReadHiLo),
        .StatClr(StatClr),
        .FWD(FWD), .Stall(Stall), .FlushE(FlushE), .MD_Busy(MD_Busy), .StallCnt(StallCnt)
    );

    function automatic logic [AW-1:0] paddr(int p);
        return D_RsAddrs[p*AW +: AW];
    endfunction

    // Youngest writing stage wins; r0 and unused ports never select a source.
    function automatic logic [1:0] ref_fwd(int p);
        logic [AW-1:0] a = paddr(p);
        if (rst || !D_RdUse[p] || a == 0) return 2'b00;
        if (E_WriteReg && E_RD == a) return 2'b01;
        if (M_WriteReg && M_RD == a) return 2'b10;
        if (W_WriteReg && W_RegWriteAddr == a) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic ref_stall();
        logic s = 1'b0;
        if (rst) return 1'b0;
        for (int p = 0; p < NRP; p++) begin
            if (ref_fwd(p) == 2'b01 && E_MemRead) s = 1'b1;
            if (ref_fwd(p) == 2'b10 && M_MemRead) s = 1'b1;
        end
        if (m_busy > 0 && (D_ReadHiLo || D_MDStart)) s = 1'b1;
        return s;
    endfunction

    task automatic tick();
        logic st = ref_stall();
        logic go = D_MDStart && !st;
        logic dv = D_MDIsDiv;
        logic cl = StatClr;
        @(posedge clk);
        if (rst) begin
            m_busy = 0;
            m_cnt  = 0;
        end else begin
            if (go) m_busy = dv ? DIV_LAT : MUL_LAT;
            else if (m_busy > 0) m_busy--;
            if (cl) m_cnt = 0;
            else if (st && m_cnt < 65535) m_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        D_RsAddrs = '0; D_RdUse = '0;
        E_WriteReg = 0; E_MemRead = 0; E_RD = '0;
        M_WriteReg = 0; M_MemRead = 0; M_RD = '0;
        W_WriteReg = 0; W_RegWriteAddr = '0;
        D_MDStart = 0; D_MDIsDiv = 0; D_ReadHiLo = 0; StatClr = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        E_WriteReg = 1; E_MemRead = 1; E_RD = 5'd3;
        D_RsAddrs[4:0] = 5'd3; D_RdUse = 2'b01;
        #1;
        checks++; if (FWD !== 4'b0000) begin errors++; $display("FAIL reset_fwd: got %b exp 0000", FWD); end
        checks++; if (Stall !== 1'b0 || FlushE !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b/%b exp 0/0", Stall, FlushE); end
        checks++; if (MD_Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", MD_Busy); end
        checks++; if (StallCnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %h exp 0000", StallCnt); end
        tick(); tick();
        clear_inputs();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_fwd_priority();
        clear_inputs();
        E_WriteReg = 1; E_RD = 5'd8; M_WriteReg = 1; M_RD = 5'd8;
        D_RsAddrs[4:0] = 5'd8; D_RdUse = 2'b01;
        #1;
        checks++; if (FWD[1:0] !== 2'b01 || Stall !== 1'b0) begin errors++; $display("FAIL fwd_e_over_m: got %b stall %b exp 01 stall 0", FWD[1:0], Stall); end
        E_WriteReg = 0; W_WriteReg = 1; W_RegWriteAddr = 5'd8;
        #1;
        checks++; if (FWD[1:0] !== 2'b10) begin errors++; $display("FAIL fwd_m_over_w: got %b exp 10", FWD[1:0]); end
        M_WriteReg = 0;
        #1;
        checks++; if (FWD[1:0] !== 2'b11) begin errors++; $display("FAIL fwd_w: got %b exp 11", FWD[1:0]); end
        D_RdUse = 2'b00;
        #1;
        checks++; if (FWD !== 4'b0000) begin errors++; $display("FAIL fwd_unused: got %b exp 0000", FWD); end
        tick();
    endtask

    task automatic test_load_use();
        clear_inputs();
        E_WriteReg = 1; E_MemRead = 1; E_RD = 5'd9;
        D_RsAddrs[9:5] = 5'd9; D_RdUse = 2'b10;
        #1;
        checks++; if (Stall !== 1'b1 || FlushE !== 1'b1) begin errors++; $display("FAIL lu_e: got %b/%b exp 1/1", Stall, FlushE); end
        checks++; if (FWD[3:2] !== 2'b01) begin errors++; $display("FAIL lu_e_fwd: got %b exp 01", FWD[3:2]); end
        tick();
        E_WriteReg = 0; E_MemRead = 0;
        M_WriteReg = 1; M_MemRead = 1; M_RD = 5'd9;
        #1;
        checks++; if (Stall !== 1'b1 || FWD[3:2] !== 2'b10) begin errors++; $display("FAIL lu_m: got stall %b fwd %b exp 1 10", Stall, FWD[3:2]); end
        tick();
        M_WriteReg = 0; M_MemRead = 0;
        W_WriteReg = 1; W_RegWriteAddr = 5'd9;
        #1;
        checks++; if (Stall !== 1'b0 || FWD[3:2] !== 2'b11) begin errors++; $display("FAIL lu_w: got stall %b fwd %b exp 0 11", Stall, FWD[3:2]); end
        tick();
    endtask

    task automatic test_mul_busy();
        clear_inputs();
        D_MDStart = 1; D_MDIsDiv = 0;
        #1;
        checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL mul_accept: got stall %b exp 0", Stall); end
        tick();
        D_MDStart = 0; D_ReadHiLo = 1;
        for (int k = 0; k < MUL_LAT; k++) begin
            #1;
            checks++; if (MD_Busy !== 1'b1 || Stall !== 1'b1) begin errors++; $display("FAIL mul_busy_%0d: got busy %b stall %b exp 1 1", k, MD_Busy, Stall); end
            tick();
        end
        #1;
        checks++; if (MD_Busy !== 1'b0 || Stall !== 1'b0) begin errors++; $display("FAIL mul_done: got busy %b stall %b exp 0 0", MD_Busy, Stall); end
        checks++; if (StallCnt !== 16'(m_cnt)) begin errors++; $display("FAIL mul_cnt: got %0d exp %0d", StallCnt, m_cnt); end
        clear_inputs();
        tick();
    endtask

    task automatic test_md_boundary();
        clear_inputs();
        D_MDStart = 1;
        tick();
        D_MDStart = 0;
        repeat (MUL_LAT - 1) tick();
        D_MDStart = 1;
        #1;
        checks++; if (MD_Busy !== 1'b1 || Stall !== 1'b1) begin errors++; $display("FAIL md_at_one: got busy %b stall %b exp 1 1", MD_Busy, Stall); end
        tick();
        #1;
        checks++; if (MD_Busy !== 1'b0 || Stall !== 1'b0) begin errors++; $display("FAIL md_at_zero: got busy %b stall %b exp 0 0", MD_Busy, Stall); end
        tick();
        D_MDStart = 0;
        #1;
        checks++; if (MD_Busy !== 1'b1) begin errors++; $display("FAIL md_reaccept: got busy %b exp 1", MD_Busy); end
        repeat (MUL_LAT) tick();
    endtask

    task automatic test_rst_abort();
        clear_inputs();
        D_MDStart = 1; D_MDIsDiv = 1;
        tick();
        D_MDStart = 0;
        repeat (3) tick();
        #2;
        rst = 1'b1;
        m_busy = 0; m_cnt = 0;
        #1;
        checks++; if (MD_Busy !== 1'b0 || StallCnt !== 16'd0) begin errors++; $display("FAIL rst_abort: got busy %b cnt %h exp 0 0000", MD_Busy, StallCnt); end
        tick(); tick();
        rst = 1'b0;
        D_MDStart = 1; D_MDIsDiv = 0;
        #1;
        checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL rst_restart_stall: got %b exp 0", Stall); end
        tick();
        D_MDStart = 0;
        #1;
        checks++; if (MD_Busy !== 1'b1) begin errors++; $display("FAIL rst_restart_busy: got %b exp 1", MD_Busy); end
        repeat (MUL_LAT) tick();
    endtask

    task automatic test_r0();
        clear_inputs();
        E_WriteReg = 1; E_MemRead = 1; M_WriteReg = 1; M_MemRead = 1; W_WriteReg = 1;
        D_RdUse = 2'b11;
        #1;
        checks++; if (FWD !== 4'b0000 || Stall !== 1'b0) begin errors++; $display("FAIL r0: got fwd %b stall %b exp 0000 0", FWD, Stall); end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            clear_inputs();
            for (int p = 0; p < NRP; p++) D_RsAddrs[p*AW +: AW] = AW'($urandom_range(0, 3));
            D_RdUse        = NRP'($urandom);
            E_WriteReg     = 1'($urandom); E_MemRead = ($urandom_range(0, 3) == 0); E_RD = AW'($urandom_range(0, 3));
            M_WriteReg     = 1'($urandom); M_MemRead = ($urandom_range(0, 3) == 0); M_RD = AW'($urandom_range(0, 3));
            W_WriteReg     = 1'($urandom); W_RegWriteAddr = AW'($urandom_range(0, 3));
            D_MDStart      = ($urandom_range(0, 7) == 0);
            D_MDIsDiv      = ($urandom_range(0, 3) == 0);
            D_ReadHiLo     = ($urandom_range(0, 7) == 0);
            StatClr        = ($urandom_range(0, 31) == 0);
            #1;
            for (int p = 0; p < NRP; p++) begin
                checks++; if (FWD[2*p +: 2] !== ref_fwd(p)) begin errors++; $display("FAIL rnd_fwd c%0d p%0d: got %b exp %b", c, p, FWD[2*p +: 2], ref_fwd(p)); end
            end
            checks++; if (Stall !== ref_stall() || FlushE !== ref_stall()) begin errors++; $display("FAIL rnd_stall c%0d: got %b/%b exp %b", c, Stall, FlushE, ref_stall()); end
            checks++; if (MD_Busy !== (m_busy > 0)) begin errors++; $display("FAIL rnd_busy c%0d: got %b exp %b", c, MD_Busy, m_busy > 0); end
            checks++; if (StallCnt !== 16'(m_cnt)) begin errors++; $display("FAIL rnd_cnt c%0d: got %0d exp %0d", c, StallCnt, m_cnt); end
            tick();
        end
        clear_inputs();
        repeat (DIV_LAT + 1) tick();
    endtask

    task automatic test_stallcnt_sat();
        clear_inputs();
        StatClr = 1;
        tick();
        StatClr = 0;
        E_WriteReg = 1; E_MemRead = 1; E_RD = 5'd1;
        D_RsAddrs[4:0] = 5'd1; D_RdUse = 2'b01;
        repeat (70000) tick();
        #1;
        checks++; if (StallCnt !== 16'hFFFF) begin errors++; $display("FAIL cnt_sat: got %h exp ffff", StallCnt); end
        StatClr = 1;
        tick();
        StatClr = 0;
        #1;
        checks++; if (StallCnt !== 16'd0) begin errors++; $display("FAIL cnt_clr: got %h exp 0000", StallCnt); end
        clear_inputs();
        tick();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_fwd_priority();
        test_load_use();
        test_mul_busy();
        test_md_boundary();
        test_rst_abort();
        test_r0();
        test_random();
        test_stallcnt_sat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
